// File: rtl/dot_pkg.sv
// Shared types for the dot update scheduler: field widths, FSM encoding and
// the buffered request record.
package dot_pkg;
  localparam int DOT_ID_W     = 5;
  localparam int DOT_LOC_W    = 10;
  localparam int NUM_DOTS_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dot_state_e;

  typedef struct packed {
    logic                 is_y;
    logic [DOT_ID_W-1:0]  id;
    logic [DOT_LOC_W-1:0] loc;
  } dot_req_t;
endpackage

// File: rtl/dot_update_sched_if.sv
// Processor write-request channel plus the dot register write strobe channel.
// slave = scheduler side, master = processor / display model side.
interface dot_update_sched_if;
  import dot_pkg::*;

  logic                 wr_valid;
  logic                 wr_ready;
  logic                 wr_is_y;
  logic [DOT_ID_W-1:0]  wr_id;
  logic [DOT_LOC_W-1:0] wr_loc;

  logic                 dot_wren;
  logic                 dot_is_y;
  logic [DOT_ID_W-1:0]  dot_id;
  logic [DOT_LOC_W-1:0] dot_loc;

  modport slave (
    input  wr_valid, wr_is_y, wr_id, wr_loc,
    output wr_ready, dot_wren, dot_is_y, dot_id, dot_loc
  );

  modport master (
    output wr_valid, wr_is_y, wr_id, wr_loc,
    input  wr_ready, dot_wren, dot_is_y, dot_id, dot_loc
  );
endinterface

// File: rtl/dot_req_fifo.sv
// Single-clock request FIFO with a registered occupancy count. Read data is
// the current head (show-ahead), so a pop consumes dout in the same cycle.
module dot_req_fifo import dot_pkg::*; #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  dot_req_t din,
  input  logic     pop,
  output dot_req_t dout,
  output logic     full,
  output logic     empty,
  output logic [AW:0] count
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  dot_req_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer/count next state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  // Control flops; reset flushes by clearing pointers and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/dot_update_sched.sv
// Dot update scheduler: buffers processor coordinate writes and drains them
// to the display dot registers in the window opened by screen_end, limited to
// MAX_PER_FRAME writes per frame, then pulses frame_ack.
// Optional: define DOT_SCHED_DROP_CNT_EN to build the saturating counter of
// discarded illegal-ID requests; otherwise drop_cnt reads 0.
module dot_update_sched import dot_pkg::*; #(
  parameter int NUM_DOTS      = NUM_DOTS_DEF,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_PER_FRAME = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic screen_end,
  dot_update_sched_if.slave bus,
  output logic frame_ack,
  output logic busy,
  output logic [7:0] drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_PER_FRAME + 1);

  dot_state_e  state_q, state_d;
  logic [CW-1:0] pop_cnt_q, pop_cnt_d;
  dot_req_t    dot_q, dot_d, head, req;
  logic        dot_wren_q, dot_wren_d;
  logic        frame_ack_q, frame_ack_d;
  logic        busy_q, busy_d;
  logic        full, empty, pop;
  logic [AW:0] occ;
  logic        accept, id_ok, push_buf;

  assign bus.wr_ready = !full;
  assign accept   = bus.wr_valid && bus.wr_ready;
  assign id_ok    = 32'(bus.wr_id) < NUM_DOTS;
  // Illegal IDs are still handshaked, just never buffered.
  assign push_buf = accept && id_ok;
  assign req      = '{is_y: bus.wr_is_y, id: bus.wr_id, loc: bus.wr_loc};

  dot_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_buf),
    .din   (req),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // Next state. The pop that produces the first strobe happens in the
  // screen_end cycle itself, so the strobe register shows it one cycle later.
  // DRAIN is left on the first cycle that cannot pop (empty or budget spent),
  // which is the cycle showing the last strobe, so frame_ack follows it.
  always_comb begin
    state_d   = state_q;
    pop_cnt_d = pop_cnt_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (screen_end)    state_d = ST_DONE;
        else if (push_buf) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (screen_end) begin
          pop       = 1'b1;
          pop_cnt_d = CW'(1);
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!empty && (32'(pop_cnt_q) < MAX_PER_FRAME)) begin
          pop       = 1'b1;
          pop_cnt_d = pop_cnt_q + CW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = (!empty || push_buf) ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    dot_wren_d  = pop;
    dot_d       = pop ? head : '0;
    frame_ack_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_DRAIN) || (state_d == ST_DONE);
  end

  // State, budget counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pop_cnt_q   <= '0;
      dot_wren_q  <= 1'b0;
      dot_q       <= '0;
      frame_ack_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_cnt_q   <= pop_cnt_d;
      dot_wren_q  <= dot_wren_d;
      dot_q       <= dot_d;
      frame_ack_q <= frame_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.dot_wren = dot_wren_q;
  assign bus.dot_is_y = dot_q.is_y;
  assign bus.dot_id   = dot_q.id;
  assign bus.dot_loc  = dot_q.loc;
  assign frame_ack    = frame_ack_q;
  assign busy         = busy_q;

`ifdef DOT_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of handshaked requests with an out-of-range ID.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !id_ok && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

  // Occupancy is only observed through full/empty here.
  logic unused_occ;
  assign unused_occ = ^occ;
endmodule

// File: tb/tb_dot_update_sched.sv
// Directed bench for dot_update_sched: default instance plus a
// MAX_PER_FRAME=4 instance for the budget case.
module tb_dot_update_sched;
  import dot_pkg::*;

`ifdef DOT_SCHED_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic se_a = 1'b0, se_b = 1'b0;
  logic fa_a, bz_a, fa_b, bz_b;
  logic [7:0] dc_a, dc_b;

  dot_update_sched_if ifa();
  dot_update_sched_if ifb();

  dot_update_sched #(.NUM_DOTS(20), .FIFO_DEPTH(16), .MAX_PER_FRAME(32)) u_dut (
    .clk(clk), .reset(reset), .screen_end(se_a), .bus(ifa),
    .frame_ack(fa_a), .busy(bz_a), .drop_cnt(dc_a));

  dot_update_sched #(.NUM_DOTS(20), .FIFO_DEPTH(16), .MAX_PER_FRAME(4)) u_dut4 (
    .clk(clk), .reset(reset), .screen_end(se_b), .bus(ifb),
    .frame_ack(fa_b), .busy(bz_b), .drop_cnt(dc_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit sel = 1'b0;
  dot_req_t got_q[$];
  dot_req_t exp_q[$];
  int ack_i, gaps, acks;

  typedef struct {
    logic       is_y;
    logic [4:0] id;
    logic [9:0] loc;
    logic       legal;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dot_req_t cur_dot();
    dot_req_t d;
    if (sel) d = '{is_y: ifb.dot_is_y, id: ifb.dot_id, loc: ifb.dot_loc};
    else     d = '{is_y: ifa.dot_is_y, id: ifa.dot_id, loc: ifa.dot_loc};
    return d;
  endfunction

  // Present one request for one clock; acc reports whether it was taken.
  task automatic push_req(input logic is_y, input logic [4:0] id, input logic [9:0] loc, output logic acc);
    if (sel) begin
      ifb.wr_valid = 1'b1; ifb.wr_is_y = is_y; ifb.wr_id = id; ifb.wr_loc = loc; acc = ifb.wr_ready;
    end else begin
      ifa.wr_valid = 1'b1; ifa.wr_is_y = is_y; ifa.wr_id = id; ifa.wr_loc = loc; acc = ifa.wr_ready;
    end
    @(negedge clk);
    ifa.wr_valid = 1'b0;
    ifb.wr_valid = 1'b0;
  endtask

  // Pulse screen_end and collect strobes until frame_ack (bounded).
  task automatic run_frame();
    got_q = {}; ack_i = -1; gaps = 0;
    if (sel) se_b = 1'b1; else se_a = 1'b1;
    @(negedge clk);
    se_a = 1'b0; se_b = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (sel ? ifb.dot_wren : ifa.dot_wren) begin
        if (got_q.size() != i) gaps++;
        got_q.push_back(cur_dot());
      end
      if (sel ? fa_b : fa_a) begin
        ack_i = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_strobes(input string name);
    chk({name, " strobe count"}, got_q.size(), exp_q.size());
    chk({name, " ack position"}, ack_i, exp_q.size());
    chk({name, " strobe gaps"}, gaps, 0);
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk({name, " payload"}, 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  function automatic dot_req_t mk(input logic is_y, input logic [4:0] id, input logic [9:0] loc);
    dot_req_t d;
    d = '{is_y: is_y, id: id, loc: loc};
    return d;
  endfunction

  initial begin
    logic acc;
    int exp_drop;
    dot_req_t e;

    ifa.wr_valid = 1'b0; ifa.wr_is_y = 1'b0; ifa.wr_id = '0; ifa.wr_loc = '0;
    ifb.wr_valid = 1'b0; ifb.wr_is_y = 1'b0; ifb.wr_id = '0; ifb.wr_loc = '0;

    vecs[0] = '{1'b0, 5'd0,  10'd1,    1'b1};
    vecs[1] = '{1'b1, 5'd20, 10'd2,    1'b0};
    vecs[2] = '{1'b0, 5'd19, 10'd1023, 1'b1};
    vecs[3] = '{1'b1, 5'd31, 10'd3,    1'b0};
    vecs[4] = '{1'b1, 5'd7,  10'd512,  1'b1};
    vecs[5] = '{1'b0, 5'd25, 10'd4,    1'b0};
    vecs[6] = '{1'b1, 5'd12, 10'd0,    1'b1};
    vecs[7] = '{1'b0, 5'd1,  10'd77,   1'b1};

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst dot_wren", ifa.dot_wren, 0);
    chk("rst dot_id", ifa.dot_id, 0);
    chk("rst frame_ack", fa_a, 0);
    chk("rst busy", bz_a, 0);
    chk("rst wr_ready", ifa.wr_ready, 1);
    chk("rst drop_cnt", dc_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-entry frame
    sel = 1'b0;
    push_req(1'b0, 5'd3, 10'd100, acc); chk("basic acc0", acc, 1);
    push_req(1'b1, 5'd3, 10'd200, acc); chk("basic acc1", acc, 1);
    chk("basic armed", u_dut.state_q, ST_ARMED);
    exp_q = {mk(1'b0, 5'd3, 10'd100), mk(1'b1, 5'd3, 10'd200)};
    run_frame();
    chk_strobes("basic");
    chk("basic busy in done", bz_a, 1);
    @(negedge clk);
    chk("basic ack width", fa_a, 0);
    chk("basic idle", u_dut.state_q, ST_IDLE);

    // Illegal id 25 three times: acked, never strobed
    for (int i = 0; i < 3; i++) begin
      push_req(1'b0, 5'd25, 10'(i), acc);
      chk("drop acc", acc, 1);
    end
    chk("drop cnt3", dc_a, DROP_EN ? 3 : 0);
    exp_q = {};
    run_frame();
    chk_strobes("drop");
    @(negedge clk);

    // Table of mixed legal/illegal requests
    exp_drop = 3;
    exp_q = {};
    foreach (vecs[i]) begin
      push_req(vecs[i].is_y, vecs[i].id, vecs[i].loc, acc);
      chk("tbl acc", acc, 1);
      if (vecs[i].legal) exp_q.push_back(mk(vecs[i].is_y, vecs[i].id, vecs[i].loc));
      else exp_drop++;
      chk("tbl drop_cnt", dc_a, DROP_EN ? exp_drop : 0);
    end
    run_frame();
    chk_strobes("tbl");
    @(negedge clk);

    // Full buffer: 16 accepted, 17th refused
    exp_q = {};
    for (int i = 0; i < 16; i++) begin
      e = mk(1'(i), 5'(i % 20), 10'(i * 7 + 1));
      push_req(e.is_y, e.id, e.loc, acc);
      chk("full acc", acc, 1);
      exp_q.push_back(e);
    end
    chk("full ready", ifa.wr_ready, 0);
    push_req(1'b1, 5'd5, 10'd999, acc);
    chk("full 17th", acc, 0);
    run_frame();
    chk_strobes("full");
    chk("full ready after", ifa.wr_ready, 1);
    @(negedge clk);

    // Push and re-pulse screen_end during DRAIN
    exp_q = {mk(1'b0, 5'd2, 10'd10), mk(1'b1, 5'd4, 10'd20), mk(1'b0, 5'd6, 10'd30)};
    foreach (exp_q[i]) push_req(exp_q[i].is_y, exp_q[i].id, exp_q[i].loc, acc);
    exp_q.push_back(mk(1'b1, 5'd9, 10'd444));
    got_q = {}; ack_i = -1; gaps = 0; acks = 0;
    se_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      ifa.wr_valid = 1'b0; se_a = 1'b0;
      if (i == 0) begin
        ifa.wr_valid = 1'b1; ifa.wr_is_y = 1'b1; ifa.wr_id = 5'd9; ifa.wr_loc = 10'd444;
      end
      if (i == 1) se_a = 1'b1;
      if (ifa.dot_wren) begin
        if (got_q.size() != i) gaps++;
        got_q.push_back(cur_dot());
      end
      if (fa_a) begin
        acks++;
        if (ack_i < 0) ack_i = i;
      end
      @(negedge clk);
    end
    ifa.wr_valid = 1'b0; se_a = 1'b0;
    chk_strobes("drainpush");
    chk("drainpush acks", acks, 1);
    chk("drainpush idle", u_dut.state_q, ST_IDLE);

    // Reset during the second strobe of a 5-entry drain
    for (int i = 0; i < 5; i++) push_req(1'b1, 5'(i + 10), 10'(i + 600), acc);
    se_a = 1'b1;
    @(negedge clk);
    se_a = 1'b0;
    @(negedge clk);
    chk("mid pre strobe", ifa.dot_wren, 1);
    reset = 1'b1;
    #1;
    chk("mid rst dot_wren", ifa.dot_wren, 0);
    chk("mid rst dot_is_y", ifa.dot_is_y, 0);
    chk("mid rst dot_id", ifa.dot_id, 0);
    chk("mid rst dot_loc", ifa.dot_loc, 0);
    chk("mid rst frame_ack", fa_a, 0);
    chk("mid rst busy", bz_a, 0);
    chk("mid rst wr_ready", ifa.wr_ready, 1);
    chk("mid rst drop_cnt", dc_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid idle", u_dut.state_q, ST_IDLE);
    exp_q = {};
    run_frame();
    chk_strobes("mid post");
    @(negedge clk);

    // Budget of 4 per frame on the second instance
    sel = 1'b1;
    exp_q = {};
    for (int i = 0; i < 6; i++) begin
      e = mk(1'b0, 5'(i + 1), 10'(i * 50 + 5));
      push_req(e.is_y, e.id, e.loc, acc);
      exp_q.push_back(e);
    end
    begin
      dot_req_t rest[$];
      rest = exp_q[4:5];
      exp_q = exp_q[0:3];
      run_frame();
      chk_strobes("budget1");
      @(negedge clk);
      chk("budget armed", u_dut4.state_q, ST_ARMED);
      exp_q = rest;
    end
    run_frame();
    chk_strobes("budget2");
    @(negedge clk);
    chk("budget idle", u_dut4.state_q, ST_IDLE);
    sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/dot_update_sched.md
DOT_UPDATE_SCHED -- requirements
Module: dot_update_sched

Interface
REQ-001 Parameter NUM_DOTS, default 20: number of dot registers in the display path; legal IDs are 0..NUM_DOTS-1.
REQ-002 Parameter FIFO_DEPTH, default 16: entries in the request buffer; power of two.
REQ-003 Parameter MAX_PER_FRAME, default 32: maximum dot writes issued per frame boundary.
REQ-004 Port clk, input, 1: 100 MHz system clock; every flop is clocked on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port screen_end, input, 1: one-cycle pulse in the clk domain marking the frame boundary.
REQ-007 Port wr_valid, input, 1: processor request valid.
REQ-008 Port wr_ready, output, 1: request buffer can accept an entry.
REQ-009 Port wr_is_y, input, 1: request targets the Y coordinate (1) or the X coordinate (0).
REQ-010 Port wr_id, input, 5: target dot ID.
REQ-011 Port wr_loc, input, 10: coordinate value.
REQ-012 Port dot_wren, output, 1: one-cycle write strobe to the display dot registers.
REQ-013 Port dot_is_y / dot_id[4:0] / dot_loc[9:0], output: write payload, valid only while dot_wren=1.
REQ-014 Port frame_ack, output, 1: one-cycle pulse when the update window for a frame has closed.
REQ-015 Port busy, output, 1: high while in DRAIN or DONE.
REQ-016 Port drop_cnt, output, 8: count of dropped illegal-ID requests.

Function
REQ-017 A request is accepted on a cycle with wr_valid=1 and wr_ready=1; wr_ready = !full.
REQ-018 An accepted request with wr_id >= NUM_DOTS is discarded, is not buffered, and is still acknowledged.
REQ-019 FSM states: IDLE (buffer empty), ARMED (buffer non-empty), DRAIN, DONE.
REQ-020 IDLE->ARMED on the first buffered push; ARMED->IDLE is not allowed.
REQ-021 On screen_end=1 in IDLE, the FSM goes to DONE.
REQ-022 On screen_end=1 in ARMED, the FSM goes to DRAIN.
REQ-023 screen_end is ignored in DRAIN and DONE; it is not queued.
REQ-024 In DRAIN, pop one entry per cycle; the first dot_wren is asserted in the cycle immediately after the screen_end cycle.
REQ-025 dot_wren and its payload are registered outputs that are held only for that one cycle.
REQ-026 DRAIN->DONE after the pop that empties the buffer, or after the MAX_PER_FRAME-th pop, whichever is first.
REQ-027 DONE lasts exactly one cycle with frame_ack=1.
REQ-028 From DONE, the FSM goes to ARMED if the buffer is non-empty, else to IDLE.
REQ-029 Simultaneous push and pop in the same cycle is legal; occupancy stays unchanged.
REQ-030 A push while full cannot happen because wr_ready=0.
REQ-031 A push arriving during DRAIN may be drained in the same window, subject to the budget.
REQ-032 Buffer order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-033 Occupancy is log2(FIFO_DEPTH)+1 bits wide; full = (occ == FIFO_DEPTH) and empty = (occ == 0).
REQ-034 The per-frame pop counter is cleared on entry to DRAIN.

Reset
REQ-035 Asserting reset, including mid-DRAIN, forces state=IDLE, flushes the buffer, and clears the pop counter and drop_cnt.
REQ-036 Output values while reset is asserted: dot_wren=0, dot_is_y=0, dot_id=0, dot_loc=0, frame_ack=0, busy=0, wr_ready=1.
REQ-037 No dot_wren is issued for any entry accepted before reset.

Configuration
REQ-038 With macro DOT_SCHED_DROP_CNT_EN defined, drop_cnt increments on each discarded illegal-ID request and saturates at 255.
REQ-039 Without DOT_SCHED_DROP_CNT_EN, drop_cnt is tied to 0 and no counter flops exist; discard behaviour is unchanged.

Structure
REQ-040 A shared package dot_pkg holds DOT_ID_W=5, DOT_LOC_W=10, the NUM_DOTS default, the FSM state encoding, and the request record type (is_y, id, loc).
REQ-041 The request buffer is a sub-module dot_req_fifo (synchronous single-clock FIFO with registered count); the FSM and budget counter are in dot_update_sched.

Verification
REQ-042 Reset, then push (x, id 3, 100) and (y, id 3, 200), then pulse screen_end -> dot_wren on the next 2 cycles in order, then frame_ack=1 for 1 cycle, then IDLE.
REQ-043 Fill 16 entries -> wr_ready=0; attempt a 17th push -> not accepted; screen_end -> 16 consecutive strobes, frame_ack, wr_ready=1.
REQ-044 Run with MAX_PER_FRAME=4 and 6 entries buffered, then screen_end -> 4 strobes and frame_ack, state ARMED; a 2nd screen_end -> 2 strobes.
REQ-045 Push wr_id=25 three times -> no strobe is ever issued; drop_cnt=3 with the macro defined and 0 without it.
REQ-046 Assert reset during the 2nd strobe of a 5-entry drain -> all outputs return to reset values; a later screen_end -> frame_ack only, with no strobe.
REQ-047 Push during DRAIN while screen_end is re-pulsed in DRAIN -> the new entry is drained in the same window and the extra screen_end is ignored (one frame_ack).
